// File: rtl/modular_inverse_stream_if.sv
// Limb-streamed operand/result bus for the modular inverse unit.
// master drives operands and result back-pressure; slave is the inverter.
interface modular_inverse_stream_if #(
  parameter int unsigned K = 128
);
  logic         mi_start;
  logic         valid_in;
  logic [K-1:0] a;
  logic [K-1:0] p;
  logic [K-1:0] r;
  logic         valid_out;
  logic         r_ready;
  logic         err;
  logic         busy;
  logic [15:0]  cycles;

  modport master (
    output mi_start, valid_in, a, p, r_ready,
    input  r, valid_out, err, busy, cycles
  );

  modport slave (
    input  mi_start, valid_in, a, p, r_ready,
    output r, valid_out, err, busy, cycles
  );
endinterface

// File: rtl/modular_inverse_stream.sv
// Streamed modular inverse r = a^-1 mod p using the binary extended Euclidean
// algorithm. Operands and result move LS limb first, N beats of K bits each.
module modular_inverse_stream #(
  parameter int unsigned K = 128,
  parameter int unsigned N = 32
) (
  input logic                     clk,
  input logic                     rst,
  modular_inverse_stream_if.slave bus
);

  localparam int unsigned W    = K * N;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {StIdle, StLoad, StCheck, StCalc, StOut} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // u_q holds operand a during load, u during CALC, and the result during OUT.
  logic [W-1:0]    u_q, u_d;
  logic [W-1:0]    v_q, v_d;
  logic [W-1:0]    x1_q, x1_d;
  logic [W-1:0]    x2_q, x2_d;
  logic [W-1:0]    p_q, p_d;
  logic            err_q, err_d;
  logic [15:0]     cycles_q, cycles_d;

  logic            last_cnt;
  logic            out_valid;
  logic [W-1:0]    x1_half, x2_half;
  logic [W-1:0]    x1_minus, x2_minus;

  assign last_cnt = (cnt_q == CntW'(N - 1));

  // Halving mod p: an odd x gets p added first; the sum needs W+1 bits before the shift.
  assign x1_half = x1_q[0] ? W'(({1'b0, x1_q} + {1'b0, p_q}) >> 1) : (x1_q >> 1);
  assign x2_half = x2_q[0] ? W'(({1'b0, x2_q} + {1'b0, p_q}) >> 1) : (x2_q >> 1);

  // Subtraction mod p: a wrapped difference plus p lands back in [0,p) modulo 2^W.
  assign x1_minus = (x1_q >= x2_q) ? (x1_q - x2_q) : (x1_q - x2_q + p_q);
  assign x2_minus = (x2_q >= x1_q) ? (x2_q - x1_q) : (x2_q - x1_q + p_q);

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      u_q      <= '0;
      v_q      <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      p_q      <= '0;
      err_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      u_q      <= u_d;
      v_q      <= v_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      p_q      <= p_d;
      err_q    <= err_d;
      cycles_q <= cycles_d;
    end
  end

  // Next-state and datapath: load limbs, validate p, one Euclid step per CALC cycle, stream out.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    u_d      = u_q;
    v_d      = v_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    p_d      = p_q;
    err_d    = err_q;
    cycles_d = cycles_q;

    unique case (state_q)
      StIdle: begin
        if (bus.mi_start) begin
          state_d  = StLoad;
          cnt_d    = '0;
          err_d    = 1'b0;
          cycles_d = '0;
        end
      end

      StLoad: begin
        if (bus.valid_in) begin
          u_d[cnt_q*K +: K] = bus.a;
          p_d[cnt_q*K +: K] = bus.p;
          cnt_d             = cnt_q + 1'b1;
          if (last_cnt) begin
            cnt_d   = '0;
            state_d = StCheck;
          end
        end
      end

      StCheck: begin
        if (!p_q[0] || (p_q == W'(1))) begin
          err_d   = 1'b1;
          u_d     = '0;
          state_d = StOut;
        end else begin
          v_d      = p_q;
          x1_d     = W'(1);
          x2_d     = '0;
          cycles_d = '0;
          state_d  = StCalc;
        end
      end

      StCalc: begin
        if (cycles_q != 16'hFFFF) cycles_d = cycles_q + 16'd1;
        if (u_q == W'(1)) begin
          u_d     = x1_q;
          state_d = StOut;
        end else if (v_q == W'(1)) begin
          u_d     = x2_q;
          state_d = StOut;
        end else if ((u_q == '0) || (v_q == '0)) begin
          u_d     = '0;
          err_d   = 1'b1;
          state_d = StOut;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = x1_half;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = x2_half;
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = x1_minus;
        end else begin
          v_d  = v_q - u_q;
          x2_d = x2_minus;
        end
      end

      StOut: begin
        if (bus.r_ready) begin
          u_d   = u_q >> K;
          cnt_d = cnt_q + 1'b1;
          if (last_cnt) begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign out_valid     = (state_q == StOut);
  assign bus.valid_out = out_valid;
  assign bus.r         = out_valid ? u_q[K-1:0] : '0;
  assign bus.err       = out_valid & err_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.cycles    = cycles_q;

endmodule

// File: tb/tb_modular_inverse_stream.sv
// Directed bench for modular_inverse_stream at K=8, N=2 (16-bit operands).
module tb_modular_inverse_stream;

  localparam int unsigned K = 8;
  localparam int unsigned N = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  modular_inverse_stream_if #(.K(K)) bus ();

  modular_inverse_stream #(.K(K), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference inverse by the classic signed extended Euclid.
  function automatic int inv_mod(input int a_v, input int p_v);
    int t, nt, rr, nr, q, tmp;
    t  = 0;
    nt = 1;
    rr = p_v;
    nr = a_v % p_v;
    while (nr != 0) begin
      q   = rr / nr;
      tmp = t - q * nt;
      t   = nt;
      nt  = tmp;
      tmp = rr - q * nr;
      rr  = nr;
      nr  = tmp;
    end
    if (t < 0) t = t + p_v;
    return t;
  endfunction

  task automatic load_op(input logic [15:0] a_v, input logic [15:0] p_v, input bit hold_start,
                         input bit gaps);
    bus.mi_start = 1'b1;
    tick();
    if (!hold_start) bus.mi_start = 1'b0;
    for (int b = 0; b < N; b++) begin
      if (gaps) begin
        bus.valid_in = 1'b0;
        bus.a        = 8'hEE;
        bus.p        = 8'hEE;
        tick();
        tick();
      end
      bus.valid_in = 1'b1;
      bus.a        = a_v[b*K +: K];
      bus.p        = p_v[b*K +: K];
      tick();
    end
    bus.valid_in = 1'b0;
    bus.mi_start = 1'b0;
  endtask

  task automatic collect(input bit start_last, output logic [15:0] r_v, output logic [1:0] e_v,
                         output bit to);
    r_v = '0;
    e_v = '0;
    to  = 1'b0;
    for (int i = 0; i < 200 && !bus.valid_out; i++) tick();
    if (!bus.valid_out) begin
      to = 1'b1;
    end else begin
      for (int b = 0; b < N; b++) begin
        r_v[b*K +: K] = bus.r;
        e_v[b]        = bus.err;
        if (start_last && b == N - 1) bus.mi_start = 1'b1;
        tick();
        bus.mi_start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.mi_start = 1'b0;
    bus.valid_in = 1'b0;
    bus.a        = '0;
    bus.p        = '0;
    bus.r_ready  = 1'b1;
    tick();
    tick();
    checks++; if (bus.valid_out !== 1'b0) begin failures++;
      $display("FAIL reset_valid_out got=%b exp=0", bus.valid_out); end
    checks++; if (bus.r !== 8'h00) begin failures++;
      $display("FAIL reset_r got=%h exp=00", bus.r); end
    checks++; if (bus.err !== 1'b0) begin failures++;
      $display("FAIL reset_err got=%b exp=0", bus.err); end
    checks++; if (bus.busy !== 1'b0) begin failures++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.cycles !== 16'd0) begin failures++;
      $display("FAIL reset_cycles got=%0d exp=0", bus.cycles); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] r_v;
    logic [1:0]  e_v;
    bit          to;
    // 3^-1 mod 7 = 5 in four CALC cycles; 10 mod 7 == 3 gives the same path length.
    logic [15:0] av [2] = '{16'h0003, 16'h000A};
    for (int i = 0; i < 2; i++) begin
      load_op(av[i], 16'h0007, 1'b0, 1'b0);
      collect(1'b0, r_v, e_v, to);
      checks++; if (to !== 1'b0) begin failures++;
        $display("FAIL basic_timeout[%0d] got=%b exp=0", i, to); end
      checks++; if (r_v !== 16'h0005) begin failures++;
        $display("FAIL basic_r[%0d] got=%h exp=0005", i, r_v); end
      checks++; if (e_v !== 2'b00) begin failures++;
        $display("FAIL basic_err[%0d] got=%b exp=00", i, e_v); end
      checks++; if (bus.cycles !== 16'd4) begin failures++;
        $display("FAIL basic_cycles[%0d] got=%0d exp=4", i, bus.cycles); end
    end
  endtask

  task automatic test_errors();
    logic [15:0] r_v;
    logic [1:0]  e_v;
    bit          to;
    // gcd 3, even p, p==1, a==0: expected CALC cycles 5, 0, 0, 1.
    logic [15:0] av [4] = '{16'h0006, 16'h0006, 16'h0000, 16'h0000};
    logic [15:0] pv [4] = '{16'h0009, 16'h000A, 16'h0001, 16'h0007};
    logic [15:0] cv [4] = '{16'd5, 16'd0, 16'd0, 16'd1};
    for (int i = 0; i < 4; i++) begin
      load_op(av[i], pv[i], 1'b0, 1'b0);
      collect(1'b0, r_v, e_v, to);
      checks++; if (to !== 1'b0) begin failures++;
        $display("FAIL err_timeout[%0d] got=%b exp=0", i, to); end
      checks++; if (r_v !== 16'h0000) begin failures++;
        $display("FAIL err_r[%0d] got=%h exp=0000", i, r_v); end
      checks++; if (e_v !== 2'b11) begin failures++;
        $display("FAIL err_flag[%0d] got=%b exp=11", i, e_v); end
      checks++; if (bus.cycles !== cv[i]) begin failures++;
        $display("FAIL err_cycles[%0d] got=%0d exp=%0d", i, bus.cycles, cv[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] r_v;
    logic [15:0] exp_r;
    int unsigned prod;
    exp_r = 16'(inv_mod(291, 61409));
    bus.r_ready = 1'b0;
    load_op(16'h0123, 16'hEFE1, 1'b0, 1'b1);
    for (int i = 0; i < 200 && !bus.valid_out; i++) tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.valid_out !== 1'b1 || bus.r !== exp_r[7:0] || bus.err !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got v=%b r=%h e=%b exp v=1 r=%h e=0", i, bus.valid_out,
                 bus.r, bus.err, exp_r[7:0]);
      end
      tick();
    end
    bus.r_ready = 1'b1;
    r_v[7:0] = bus.r;
    tick();
    checks++; if (bus.valid_out !== 1'b1 || bus.r !== exp_r[15:8]) begin failures++;
      $display("FAIL bp_beat1 got v=%b r=%h exp v=1 r=%h", bus.valid_out, bus.r, exp_r[15:8]); end
    r_v[15:8] = bus.r;
    tick();
    checks++; if (bus.valid_out !== 1'b0 || bus.busy !== 1'b0) begin failures++;
      $display("FAIL bp_end got v=%b busy=%b exp v=0 busy=0", bus.valid_out, bus.busy); end
    prod = (int'(r_v) * 291) % 61409;
    checks++; if (prod !== 1) begin failures++;
      $display("FAIL bp_product got=%0d exp=1 (r=%h)", prod, r_v); end
    checks++; if (bus.cycles == 16'd0 || bus.cycles > 16'd66) begin failures++;
      $display("FAIL bp_cycles got=%0d exp=1..66", bus.cycles); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] r_v;
    logic [1:0]  e_v;
    bit          to;
    load_op(16'h0123, 16'hEFE1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    checks++; if (bus.busy !== 1'b1) begin failures++;
      $display("FAIL rstmid_busy_before got=%b exp=1", bus.busy); end
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.valid_out !== 1'b0 || bus.r !== 8'h00 ||
                  bus.err !== 1'b0 || bus.cycles !== 16'd0) begin failures++;
      $display("FAIL rstmid_outputs got busy=%b v=%b r=%h e=%b cyc=%0d exp all 0", bus.busy,
               bus.valid_out, bus.r, bus.err, bus.cycles);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.valid_out !== 1'b0 || bus.busy !== 1'b0) begin failures++;
      $display("FAIL rstmid_idle got v=%b busy=%b exp 0 0", bus.valid_out, bus.busy); end
    load_op(16'h0003, 16'h0007, 1'b0, 1'b0);
    collect(1'b0, r_v, e_v, to);
    checks++; if (to !== 1'b0 || r_v !== 16'h0005 || e_v !== 2'b00) begin failures++;
      $display("FAIL rstmid_fresh got to=%b r=%h e=%b exp to=0 r=0005 e=00", to, r_v, e_v); end
  endtask

  task automatic test_protocol();
    logic [15:0] r_v;
    logic [1:0]  e_v;
    bit          to;
    // valid_in while idle must not start or load anything.
    bus.valid_in = 1'b1;
    bus.a        = 8'hFF;
    bus.p        = 8'hFF;
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0) begin failures++;
      $display("FAIL proto_idle_busy got=%b exp=0", bus.busy); end
    bus.valid_in = 1'b0;
    load_op(16'h0003, 16'h0007, 1'b1, 1'b0);
    // Junk on every input through CHECK and early CALC.
    bus.mi_start = 1'b1;
    bus.valid_in = 1'b1;
    bus.a        = 8'hFF;
    bus.p        = 8'hFF;
    tick();
    tick();
    tick();
    bus.mi_start = 1'b0;
    bus.valid_in = 1'b0;
    collect(1'b1, r_v, e_v, to);
    checks++; if (to !== 1'b0 || r_v !== 16'h0005 || e_v !== 2'b00) begin failures++;
      $display("FAIL proto_result got to=%b r=%h e=%b exp to=0 r=0005 e=00", to, r_v, e_v); end
    checks++; if (bus.cycles !== 16'd4) begin failures++;
      $display("FAIL proto_cycles got=%0d exp=4", bus.cycles); end
    checks++; if (bus.busy !== 1'b0 || bus.valid_out !== 1'b0) begin failures++;
      $display("FAIL proto_last_start got busy=%b v=%b exp 0 0", bus.busy, bus.valid_out); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin failures++;
      $display("FAIL proto_stay_idle got=%b exp=0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
